// File: rtl/ee_buf_scan_if.sv
// rtl/ee_buf_scan_if.sv - run/level symbol stream between the buffer scanner and the Huffman coder
//
// Signals (master = scanner, slave = Huffman coder):
//   sym_valid    symbol present
//   sym_ready    coder accepts the symbol
//   sym_cmp      block index within the MB
//   sym_dc       symbol is the DC term
//   sym_eob      symbol is EOB
//   sym_run      zero run (15 for ZRL, 0 for DC/EOB)
//   sym_level    signed level (0 for ZRL/EOB)
//   sym_last_mb  MB is the last of the picture
interface ee_buf_scan_if #(
    parameter int COEF_W = 12
);
    logic              sym_valid;
    logic              sym_ready;
    logic [1:0]        sym_cmp;
    logic              sym_dc;
    logic              sym_eob;
    logic [3:0]        sym_run;
    logic [COEF_W-1:0] sym_level;
    logic              sym_last_mb;

    modport master (
        output sym_valid, sym_cmp, sym_dc, sym_eob, sym_run, sym_level, sym_last_mb,
        input  sym_ready
    );

    modport slave (
        input  sym_valid, sym_cmp, sym_dc, sym_eob, sym_run, sym_level, sym_last_mb,
        output sym_ready
    );
endinterface

// File: rtl/ee_buf_scan.sv
// rtl/ee_buf_scan.sv - zigzag run/level scanner from ee_buf to the Huffman coder
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   wr_ee_buf_ready   writer pulse: one MB buffer completely written
//   cena_ee_buf       ee_buf port A read enable (active low)
//   aa_ee_buf         ee_buf port A word address
//   rid_ee_buf        buffer id being read
//   qa_ee_buf         ee_buf port A read data, one cycle after cena_ee_buf low
//   sym               symbol stream (master side)
//   rd_ee_buf_done    pulse: buffer released
//   ee_buf_full       both buffers occupied
//   ovf_err           sticky: write pulse while full
module ee_buf_scan #(
    parameter int CMP_NUM = 3,
    parameter int COEF_W  = 12
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                wr_ee_buf_ready,
    output logic                cena_ee_buf,
    output logic [5:0]          aa_ee_buf,
    output logic                rid_ee_buf,
    input  logic [8*COEF_W-1:0] qa_ee_buf,
    ee_buf_scan_if.master       sym,
    output logic                rd_ee_buf_done,
    output logic                ee_buf_full,
    output logic                ovf_err
);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    // Zigzag position -> coefficient register index. The register is
    // column-major (col*8 + row), so this is the transposed JPEG order.
    localparam logic [5:0] DEZZ [64] = '{
        6'd0,  6'd8,  6'd1,  6'd2,  6'd9,  6'd16, 6'd24, 6'd17, 6'd10, 6'd3,  6'd4,  6'd11, 6'd18, 6'd25, 6'd32, 6'd40,
        6'd33, 6'd26, 6'd19, 6'd12, 6'd5,  6'd6,  6'd13, 6'd20, 6'd27, 6'd34, 6'd41, 6'd48, 6'd56, 6'd49, 6'd42, 6'd35,
        6'd28, 6'd21, 6'd14, 6'd7,  6'd15, 6'd22, 6'd29, 6'd36, 6'd43, 6'd50, 6'd57, 6'd58, 6'd51, 6'd44, 6'd37, 6'd30,
        6'd23, 6'd31, 6'd38, 6'd45, 6'd52, 6'd59, 6'd60, 6'd53, 6'd46, 6'd39, 6'd47, 6'd54, 6'd61, 6'd62, 6'd55, 6'd63
    };

    state_t                   state, state_nxt;
    logic [1:0]               cnt;
    logic [3:0]               ld_cnt;
    logic [2:0]               row_sel;
    logic [1:0]               cmp;
    logic [62:0]              nz;        // zigzag 1..63; DC is always emitted so its flag is not kept
    logic                     last_mb;
    logic [5:0]               k;         // zigzag position of the last emitted coefficient
    logic                     dc_pend;
    logic signed [COEF_W-1:0] coef [64];
    logic                     found;
    logic [5:0]               n;
    logic [5:0]               gap;
    logic                     fire;
    logic                     blk_end;
    logic                     last_blk;

    assign ee_buf_full = (cnt == 2'd2);
    assign fire        = sym.sym_valid && sym.sym_ready;
    assign row_sel     = 3'(ld_cnt - 4'd2);
    assign last_blk    = (cmp == 2'(CMP_NUM - 1));

    // Lowest set nz position strictly after k.
    always_comb begin
        found = 1'b0;
        n     = 6'd0;
        for (int i = 63; i >= 1; i--) begin
            if (6'(i) > k && nz[6'(63 - i)]) begin
                found = 1'b1;
                n     = 6'(i);
            end
        end
        gap = n - k - 6'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        cena_ee_buf     = 1'b1;
        aa_ee_buf       = 6'd0;
        rd_ee_buf_done  = 1'b0;
        blk_end         = 1'b0;
        sym.sym_valid   = 1'b0;
        sym.sym_cmp     = 2'd0;
        sym.sym_dc      = 1'b0;
        sym.sym_eob     = 1'b0;
        sym.sym_run     = 4'd0;
        sym.sym_level   = '0;
        sym.sym_last_mb = 1'b0;
        case (state)
            IDLE: if (cnt != 2'd0) state_nxt = LOAD;
            LOAD: begin
                // nz word first, then rows 0..7; the tenth cycle only captures row 7.
                if (ld_cnt <= 4'd8) begin
                    cena_ee_buf = 1'b0;
                    aa_ee_buf   = (ld_cnt == 4'd0) ? 6'(CMP_NUM * 8) + 6'(cmp)
                                                   : 6'({cmp, 3'b000}) + 6'(ld_cnt - 4'd1);
                end
                if (ld_cnt == 4'd9) state_nxt = SCAN;
            end
            SCAN: begin
                sym.sym_valid   = 1'b1;
                sym.sym_cmp     = cmp;
                sym.sym_last_mb = last_mb;
                if (dc_pend) begin
                    sym.sym_dc    = 1'b1;
                    sym.sym_level = coef[0];
                end else if (!found) begin
                    sym.sym_eob = 1'b1;
                    blk_end     = 1'b1;
                end else if (gap > 6'd15) begin
                    sym.sym_run = 4'd15;
                end else begin
                    sym.sym_run   = gap[3:0];
                    sym.sym_level = coef[DEZZ[n]];
                    blk_end       = (n == 6'd63);   // last position reached: no EOB follows
                end
                if (blk_end && sym.sym_ready) state_nxt = last_blk ? DONE : LOAD;
            end
            DONE: begin
                rd_ee_buf_done = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_cnt  <= 4'd0;
            cmp     <= 2'd0;
            k       <= 6'd0;
            dc_pend <= 1'b0;
            nz      <= '0;
            last_mb <= 1'b0;
        end else begin
            if (state == LOAD) begin
                ld_cnt <= (ld_cnt == 4'd9) ? 4'd0 : ld_cnt + 4'd1;
                if (ld_cnt == 4'd1) begin
                    nz      <= qa_ee_buf[62:0];
                    last_mb <= qa_ee_buf[64];
                end
                if (ld_cnt == 4'd9) begin
                    k       <= 6'd0;
                    dc_pend <= 1'b1;
                end
            end
            if (fire) begin
                if (dc_pend)          dc_pend <= 1'b0;
                else if (blk_end)     cmp <= last_blk ? 2'd0 : cmp + 2'd1;
                else if (gap > 6'd15) k <= k + 6'd16;
                else                  k <= n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && ld_cnt >= 4'd2) begin
            for (int j = 0; j < 8; j++)
                coef[{3'(j), row_sel}] <= qa_ee_buf[(8-j)*COEF_W-1 -: COEF_W];
        end
    end

    // Occupancy: a write and a release in the same cycle cancel out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= 2'd0;
            rid_ee_buf <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            if (wr_ee_buf_ready && ee_buf_full) ovf_err <= 1'b1;
            case ({wr_ee_buf_ready, rd_ee_buf_done})
                2'b10:   if (!ee_buf_full) cnt <= cnt + 2'd1;
                2'b01:   if (cnt != 2'd0)  cnt <= cnt - 2'd1;
                default: ;
            endcase
            if (rd_ee_buf_done) rid_ee_buf <= ~rid_ee_buf;
        end
    end

endmodule

// File: tb/tb_ee_buf_scan.sv
// tb/tb_ee_buf_scan.sv - randomized scoreboard bench for ee_buf_scan
module tb_ee_buf_scan;
    localparam int CMP_NUM = 3;
    localparam int COEF_W  = 12;
    localparam int DW      = 8 * COEF_W;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          wr_ee_buf_ready = 1'b0;
    logic          cena_ee_buf;
    logic [5:0]    aa_ee_buf;
    logic          rid_ee_buf;
    logic [DW-1:0] qa_ee_buf;
    logic          rd_ee_buf_done;
    logic          ee_buf_full;
    logic          ovf_err;

    ee_buf_scan_if #(.COEF_W(COEF_W)) sif ();

    ee_buf_scan #(.CMP_NUM(CMP_NUM), .COEF_W(COEF_W)) dut (
        .clk(clk), .rstn(rstn), .wr_ee_buf_ready(wr_ee_buf_ready),
        .cena_ee_buf(cena_ee_buf), .aa_ee_buf(aa_ee_buf), .rid_ee_buf(rid_ee_buf),
        .qa_ee_buf(qa_ee_buf), .sym(sif.master), .rd_ee_buf_done(rd_ee_buf_done),
        .ee_buf_full(ee_buf_full), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [2][64];
    always @(posedge clk) if (!cena_ee_buf) qa_ee_buf <= mem[rid_ee_buf][aa_ee_buf];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] pk(input logic [1:0] c, input logic dc, input logic eob,
                                       input logic [3:0] run, input logic [11:0] lvl, input logic last);
        return {c, dc, eob, run, lvl, last};
    endfunction

    // zigzag position -> (row, col), walked diagonal by diagonal
    int zr [64];
    int zc [64];
    task automatic init_zz();
        int idx = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 1) begin
                for (int r = 0; r < 8; r++)
                    if (s - r >= 0 && s - r < 8) begin zr[idx] = r; zc[idx] = s - r; idx++; end
            end else begin
                for (int r = 7; r >= 0; r--)
                    if (s - r >= 0 && s - r < 8) begin zr[idx] = r; zc[idx] = s - r; idx++; end
            end
        end
    endtask

    logic [63:0]        bnz [CMP_NUM];        // bit i = zigzag position i
    logic signed [11:0] bco [CMP_NUM][8][8];  // [row][col]
    logic [20:0]        expq [$];
    logic               wbuf = 1'b0;
    int                 writes_acc = 0;
    int                 dones = 0;
    int                 acc = 0;
    int                 stall_seq = 0;
    logic               exp_rid = 1'b0;

    task automatic clr_blocks();
        for (int c = 0; c < CMP_NUM; c++) begin
            bnz[c] = '0;
            for (int r = 0; r < 8; r++) for (int j = 0; j < 8; j++) bco[c][r][j] = '0;
        end
    endtask

    task automatic rand_blocks();
        int p, v;
        clr_blocks();
        for (int c = 0; c < CMP_NUM; c++) begin
            case ($urandom_range(0, 4))
                0: p = 0;
                1: p = 3;
                2: p = 12;
                3: p = 40;
                default: p = 100;
            endcase
            bco[c][0][0] = 12'($urandom);
            bnz[c][0] = 1'b1;
            for (int i = 1; i < 64; i++)
                if (int'($urandom_range(0, 99)) < p) begin
                    v = int'($urandom_range(1, 2047));
                    if ($urandom_range(0, 1) == 1) v = -v;
                    bnz[c][i] = 1'b1;
                    bco[c][zr[i]][zc[i]] = 12'(v);
                end
        end
    endtask

    // Write the MB into buffer wbuf and queue its expected JPEG symbols.
    task automatic fill_mb(input logic last);
        logic [DW-1:0] w;
        int run, lastnz;
        for (int c = 0; c < CMP_NUM; c++) begin
            w = '0;
            w[64] = last;
            for (int i = 0; i < 64; i++) w[63-i] = bnz[c][i];
            mem[wbuf][CMP_NUM*8+c] = w;
            for (int r = 0; r < 8; r++) begin
                w = '0;
                for (int j = 0; j < 8; j++) w[(8-j)*COEF_W-1 -: COEF_W] = bco[c][r][j];
                mem[wbuf][c*8+r] = w;
            end
            expq.push_back(pk(2'(c), 1'b1, 1'b0, 4'd0, bco[c][0][0], last));
            lastnz = 0;
            run = 0;
            for (int i = 1; i < 64; i++) begin
                if (bnz[c][i]) begin
                    while (run > 15) begin
                        expq.push_back(pk(2'(c), 1'b0, 1'b0, 4'd15, 12'd0, last));
                        run -= 16;
                    end
                    expq.push_back(pk(2'(c), 1'b0, 1'b0, 4'(run), bco[c][zr[i]][zc[i]], last));
                    run = 0;
                    lastnz = i;
                end else begin
                    run++;
                end
            end
            if (lastnz < 63) expq.push_back(pk(2'(c), 1'b0, 1'b1, 4'd0, 12'd0, last));
        end
    endtask

    task automatic pulse_wr();
        @(negedge clk);
        wr_ee_buf_ready = 1'b1;
        @(posedge clk);
        #1;
        wr_ee_buf_ready = 1'b0;
    endtask

    task automatic commit_mb(input logic last);
        fill_mb(last);
        pulse_wr();
        wbuf = ~wbuf;
        writes_acc++;
    endtask

    task automatic wait_dones(input int target);
        int t = 0;
        while (dones < target && t < 4000) begin @(posedge clk); t++; end
        chk("done_timeout", 32'(dones >= target), 32'd1);
    endtask

    task automatic wait_slot();
        int t = 0;
        while (writes_acc - dones >= 2 && t < 4000) begin @(posedge clk); t++; end
        chk("slot_timeout", 32'(t < 4000), 32'd1);
    endtask

    // Ready driver: random backpressure plus on-demand 5-cycle stalls.
    int stall_cnt = 0;
    int stall_seen = 0;
    initial begin
        sif.sym_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_seq != stall_seen) begin stall_seen = stall_seq; stall_cnt = 5; end
            if (stall_cnt > 0) begin
                sif.sym_ready = 1'b0;
                stall_cnt--;
            end else begin
                sif.sym_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Scoreboard monitor
    logic [20:0] cur;
    logic [20:0] hold_sym;
    logic        hold_v = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            hold_v  = 1'b0;
            exp_rid = 1'b0;
            expq.delete();
        end else begin
            cur = pk(sif.sym_cmp, sif.sym_dc, sif.sym_eob, sif.sym_run, sif.sym_level, sif.sym_last_mb);
            if (hold_v) chk("stall_hold", {10'd0, sif.sym_valid, cur}, {10'd0, 1'b1, hold_sym});
            hold_v   = sif.sym_valid && !sif.sym_ready;
            hold_sym = cur;
            if (sif.sym_valid && sif.sym_ready) begin
                acc++;
                if (expq.size() == 0) chk("sym_extra", 32'd1, 32'd0);
                else                  chk("sym", {11'd0, cur}, {11'd0, expq.pop_front()});
            end
            if (rd_ee_buf_done) begin
                chk("rid_at_done", {31'd0, rid_ee_buf}, {31'd0, exp_rid});
                exp_rid = ~exp_rid;
                dones++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t, a0;
        logic r0;
        init_zz();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cena", {31'd0, cena_ee_buf}, 32'd1);
        chk("rst_aa", {26'd0, aa_ee_buf}, 32'd0);
        chk("rst_rid", {31'd0, rid_ee_buf}, 32'd0);
        chk("rst_valid", {31'd0, sif.sym_valid}, 32'd0);
        chk("rst_sym", {11'd0, pk(sif.sym_cmp, sif.sym_dc, sif.sym_eob, sif.sym_run, sif.sym_level, sif.sym_last_mb)}, 32'd0);
        chk("rst_flags", {29'd0, rd_ee_buf_done, ee_buf_full, ovf_err}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // all-zero blocks: DC(0), EOB per block, one release
        clr_blocks();
        commit_mb(1'b0);
        lat = 0;
        while (!sif.sym_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("dc_latency", 32'(lat), 32'd11);
        wait_dones(writes_acc);
        chk("done_count", 32'(dones), 32'd1);
        chk("full_after_drain", {31'd0, ee_buf_full}, 32'd0);

        // directed blocks, last_mb set, 5-cycle stall mid-scan
        clr_blocks();
        bnz[0][0] = 1'b1; bnz[0][1] = 1'b1;
        bco[0][0][0] = -12'sd5;
        bco[0][zr[1]][zc[1]] = 12'sd3;
        bnz[1][0] = 1'b1; bnz[1][40] = 1'b1;
        bco[1][0][0] = 12'sd7;
        bco[1][zr[40]][zc[40]] = -12'sd1;
        bnz[2] = '1;
        for (int r = 0; r < 8; r++) for (int j = 0; j < 8; j++) bco[2][r][j] = 12'(j * 8 + r - 32);
        a0 = acc;
        commit_mb(1'b1);
        t = 0;
        while (acc < a0 + 20 && t < 2000) begin @(posedge clk); t++; end
        chk("reach_mid_scan", 32'(acc >= a0 + 20), 32'd1);
        stall_seq++;
        wait_dones(writes_acc);
        chk("q_empty_dir", 32'(expq.size()), 32'd0);

        // occupancy: two writes fill, third overflows, write+release keeps count
        rand_blocks();
        commit_mb(1'b0);
        rand_blocks();
        commit_mb(1'b0);
        @(negedge clk);
        chk("full_two", {31'd0, ee_buf_full}, 32'd1);
        chk("no_ovf_yet", {31'd0, ovf_err}, 32'd0);
        pulse_wr();
        @(negedge clk);
        chk("ovf_set", {31'd0, ovf_err}, 32'd1);
        chk("full_sat", {31'd0, ee_buf_full}, 32'd1);
        t = 0;
        while (!rd_ee_buf_done && t < 4000) begin @(negedge clk); t++; end
        chk("done_seen", {31'd0, rd_ee_buf_done}, 32'd1);
        r0 = rid_ee_buf;
        rand_blocks();
        fill_mb(1'b0);
        wr_ee_buf_ready = 1'b1;
        @(posedge clk);
        #1;
        wr_ee_buf_ready = 1'b0;
        wbuf = ~wbuf;
        writes_acc++;
        chk("full_simul", {31'd0, ee_buf_full}, 32'd1);
        chk("rid_toggle", {31'd0, rid_ee_buf}, {31'd0, ~r0});
        wait_dones(writes_acc);
        chk("full_drained", {31'd0, ee_buf_full}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf_err}, 32'd1);
        chk("q_empty_occ", 32'(expq.size()), 32'd0);

        // asynchronous reset mid-scan
        rand_blocks();
        commit_mb(1'b0);
        t = 0;
        while (!sif.sym_valid && t < 100) begin @(posedge clk); #1; t++; end
        repeat (3) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("abort_cena", {31'd0, cena_ee_buf}, 32'd1);
        chk("abort_valid", {31'd0, sif.sym_valid}, 32'd0);
        chk("abort_flags", {28'd0, rid_ee_buf, rd_ee_buf_done, ee_buf_full, ovf_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        wbuf = 1'b0;
        writes_acc = dones;

        // random MBs with random backpressure
        for (int m = 0; m < 10; m++) begin
            wait_slot();
            rand_blocks();
            commit_mb(1'($urandom_range(0, 1)));
        end
        wait_dones(writes_acc);
        chk("q_empty_rand", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
